// File: rtl/uart_arb_pkg.sv
// Shared types and widths for the UART transmit arbiter.
package uart_arb_pkg;

  localparam int BYTE_W = 8;
  localparam int PKT_W  = 16;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SEND_HI = 3'd1,
    WAIT_HI = 3'd2,
    SEND_LO = 3'd3,
    WAIT_LO = 3'd4,
    DONE    = 3'd5
  } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: searches upward from rr_ptr+1 (mod NUM_REQ),
// so the requester served last has the lowest priority.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int GW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [GW-1:0]      rr_ptr,
  output logic               gnt_valid,
  output logic [GW-1:0]      gnt_idx
);

  logic [GW-1:0] cand_s;

  // First requesting index after rr_ptr wins
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    cand_s    = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand_s = GW'((int'(rr_ptr) + i) % NUM_REQ);
      if (!gnt_valid && req[cand_s]) begin
        gnt_valid = 1'b1;
        gnt_idx   = cand_s;
      end else begin
        gnt_idx   = gnt_idx;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter among NUM_REQ packet sources;
// sends 1- or 2-byte packets, pacing each byte on the rising edge of tx_done.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [16*NUM_REQ-1:0]    pkt_data,
  input  logic [NUM_REQ-1:0]       pkt_two,
  output logic [NUM_REQ-1:0]       ack,
  output logic                     busy,
  output logic                     trmt,
  output logic [7:0]               tx_data,
  input  logic                     tx_done
);

  localparam int GW = $clog2(NUM_REQ);

  arb_state_t          state_q, state_d;
  logic [GW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [GW-1:0]       win_q, win_d;
  logic [BYTE_W-1:0]   pkt_lo_q, pkt_lo_d;
  logic [BYTE_W-1:0]   tx_data_q, tx_data_d;
  logic [NUM_REQ-1:0]  ack_q, ack_d;
  logic                trmt_q, trmt_d;
  logic                busy_q, busy_d;
  logic                tx_done_q;

  logic                gnt_valid_s;
  logic [GW-1:0]       gnt_idx_s;
  logic [PKT_W-1:0]    gnt_pkt_s;
  logic                tx_done_rise_s;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .GW(GW)) u_rr (
    .req       (req),
    .rr_ptr    (rr_ptr_q),
    .gnt_valid (gnt_valid_s),
    .gnt_idx   (gnt_idx_s)
  );

  assign tx_done_rise_s = tx_done & ~tx_done_q;

  // AND-OR mux of the granted requester's packet
  always_comb begin
    gnt_pkt_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      gnt_pkt_s = gnt_pkt_s | (pkt_data[i*PKT_W +: PKT_W] & {PKT_W{gnt_idx_s == GW'(i)}});
    end
  end

  // Next-state and output computation; the high byte goes straight from the
  // live packet because it is loaded at the grant edge, only the low byte is kept
  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    win_d     = win_q;
    pkt_lo_d  = pkt_lo_q;
    tx_data_d = tx_data_q;
    busy_d    = busy_q;
    trmt_d    = 1'b0;
    ack_d     = '0;
    case (state_q)
      IDLE: begin
        if (gnt_valid_s) begin
          win_d    = gnt_idx_s;
          pkt_lo_d = gnt_pkt_s[7:0];
          busy_d   = 1'b1;
          trmt_d   = 1'b1;
          if (pkt_two[gnt_idx_s]) begin
            state_d   = SEND_HI;
            tx_data_d = gnt_pkt_s[15:8];
          end else begin
            state_d   = SEND_LO;
            tx_data_d = gnt_pkt_s[7:0];
          end
        end else begin
          state_d = IDLE;
        end
      end
      SEND_HI: state_d = WAIT_HI;
      SEND_LO: state_d = WAIT_LO;
      WAIT_HI: begin
        if (tx_done_rise_s) begin
          state_d   = SEND_LO;
          trmt_d    = 1'b1;
          tx_data_d = pkt_lo_q;
        end else begin
          state_d = WAIT_HI;
        end
      end
      WAIT_LO: begin
        if (tx_done_rise_s) begin
          state_d       = DONE;
          ack_d[win_q]  = 1'b1;
        end else begin
          state_d = WAIT_LO;
        end
      end
      DONE: begin
        state_d  = IDLE;
        rr_ptr_d = win_q;
        busy_d   = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State, capture and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rr_ptr_q  <= GW'(NUM_REQ - 1);
      win_q     <= '0;
      pkt_lo_q  <= 8'h00;
      tx_data_q <= 8'h00;
      ack_q     <= '0;
      trmt_q    <= 1'b0;
      busy_q    <= 1'b0;
      tx_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      win_q     <= win_d;
      pkt_lo_q  <= pkt_lo_d;
      tx_data_q <= tx_data_d;
      ack_q     <= ack_d;
      trmt_q    <= trmt_d;
      busy_q    <= busy_d;
      tx_done_q <= tx_done;
    end
  end

  assign ack     = ack_q;
  assign busy    = busy_q;
  assign trmt    = trmt_q;
  assign tx_data = tx_data_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a small behavioural UART_tx in the loop.
module tb_uart_tx_arbiter;

  localparam int LAT = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req = 2'b00;
  logic [31:0] pkt_data = 32'h0;
  logic [1:0]  pkt_two = 2'b00;
  logic [1:0]  ack;
  logic        busy;
  logic        trmt;
  logic [7:0]  tx_data;
  logic        tx_done;

  logic        uart_done;
  int          uart_cnt;
  logic        force_en = 1'b0;
  logic        force_val = 1'b0;

  int          n_tests = 0;
  int          n_fail = 0;
  int          overlap_cnt = 0;
  int          multi_cnt = 0;
  logic [7:0]  byte_log[$];

  typedef struct {
    logic [1:0]  req;
    logic [31:0] data;
    logic [1:0]  two;
    int          nbytes;
    logic [7:0]  b0;
    logic [7:0]  b1;
    int          ack_idx;
  } vec_t;

  vec_t vecs[6];

  uart_tx_arbiter #(.NUM_REQ(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .pkt_data (pkt_data),
    .pkt_two  (pkt_two),
    .ack      (ack),
    .busy     (busy),
    .trmt     (trmt),
    .tx_data  (tx_data),
    .tx_done  (tx_done)
  );

  always #5 clk = ~clk;

  assign tx_done = force_en ? force_val : uart_done;

  // UART_tx stand-in: trmt clears tx_done, which rises LAT cycles later and holds
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      uart_done <= 1'b0;
      uart_cnt  <= 0;
    end else if (trmt) begin
      uart_done <= 1'b0;
      uart_cnt  <= LAT;
    end else if (uart_cnt > 0) begin
      uart_cnt <= uart_cnt - 1;
      if (uart_cnt == 1) uart_done <= 1'b1;
    end
  end

  // Byte log and output-exclusivity monitor
  always @(negedge clk) begin
    if (rst_n) begin
      if (trmt) byte_log.push_back(tx_data);
      if (trmt && (|ack)) overlap_cnt <= overlap_cnt + 1;
      if ($countones(ack) > 1) multi_cnt <= multi_cnt + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_ack(output int idx, output bit ok);
    ok  = 1'b0;
    idx = -1;
    for (int c = 0; c < 300 && !ok; c++) begin
      @(negedge clk);
      if (|ack) begin
        ok  = 1'b1;
        idx = ack[1] ? 1 : 0;
      end
    end
    if (!ok) chk("ack_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_trmt();
    bit ok = 1'b0;
    for (int c = 0; c < 50 && !ok; c++) begin
      @(negedge clk);
      if (trmt) ok = 1'b1;
    end
    if (!ok) chk("trmt_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req       = 2'b00;
    force_en  = 1'b0;
    force_val = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    byte_log.delete();
  endtask

  task automatic check_bytes(input string tag, input int n, input logic [7:0] b0, input logic [7:0] b1);
    chk({tag, "_nbytes"}, byte_log.size(), n);
    if (byte_log.size() >= 1) chk({tag, "_byte0"}, byte_log[0], b0);
    if (n == 2 && byte_log.size() >= 2) chk({tag, "_byte1"}, byte_log[1], b1);
  endtask

  task automatic run_vec(input int i);
    int idx;
    bit ok;
    string tag;
    tag = $sformatf("vec%0d", i);
    @(negedge clk);
    byte_log.delete();
    req      = vecs[i].req;
    pkt_data = vecs[i].data;
    pkt_two  = vecs[i].two;
    @(negedge clk);
    chk({tag, "_latency_trmt"}, trmt, 1);
    wait_ack(idx, ok);
    if (ok) begin
      chk({tag, "_ack_idx"}, idx, vecs[i].ack_idx);
      chk({tag, "_busy_at_ack"}, busy, 1);
    end
    req = 2'b00;
    @(negedge clk);
    chk({tag, "_busy_after_ack"}, busy, 0);
    chk({tag, "_ack_one_cycle"}, ack, 0);
    check_bytes(tag, vecs[i].nbytes, vecs[i].b0, vecs[i].b1);
  endtask

  initial begin
    int idx;
    bit ok;

    vecs[0] = '{2'b01, {16'h0000, 16'hA55A}, 2'b01, 2, 8'hA5, 8'h5A, 0};
    vecs[1] = '{2'b10, {16'h12C3, 16'h0000}, 2'b00, 1, 8'hC3, 8'h00, 1};
    vecs[2] = '{2'b01, {16'h0000, 16'h00FF}, 2'b00, 1, 8'hFF, 8'h00, 0};
    vecs[3] = '{2'b10, {16'h8001, 16'h0000}, 2'b10, 2, 8'h80, 8'h01, 1};
    vecs[4] = '{2'b11, {16'h5678, 16'h1234}, 2'b11, 2, 8'h12, 8'h34, 0};
    vecs[5] = '{2'b11, {16'h5678, 16'h1234}, 2'b01, 1, 8'h78, 8'h00, 1};

    // reset values
    repeat (2) @(negedge clk);
    chk("rst_trmt", trmt, 0);
    chk("rst_ack", ack, 0);
    chk("rst_busy", busy, 0);
    chk("rst_tx_data", tx_data, 8'h00);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) run_vec(i);

    // back-to-back rotation with both requests held
    do_reset();
    pkt_data = {16'h0022, 16'h0011};
    pkt_two  = 2'b00;
    req      = 2'b11;
    for (int k = 0; k < 4; k++) begin
      wait_ack(idx, ok);
      chk($sformatf("rr_order%0d", k), idx, k % 2);
      if (k == 3) begin
        req = 2'b00;
      end else begin
        @(negedge clk);
        chk($sformatf("rr_idle%0d", k), trmt, 0);
        @(negedge clk);
        chk($sformatf("rr_gap%0d", k), trmt, 1);
      end
    end
    @(negedge clk);
    chk("rr_nbytes", byte_log.size(), 4);
    for (int k = 0; k < 4 && k < byte_log.size(); k++)
      chk($sformatf("rr_byte%0d", k), byte_log[k], (k % 2 == 0) ? 8'h11 : 8'h22);

    // tx_done held high in WAIT_HI advances once only
    do_reset();
    pkt_data = {16'h0000, 16'hA55A};
    pkt_two  = 2'b01;
    req      = 2'b01;
    wait_trmt();
    @(negedge clk);
    force_en  = 1'b1;
    force_val = 1'b1;
    begin
      int n_trmt = 0;
      int n_ack  = 0;
      repeat (20) begin
        @(negedge clk);
        if (trmt) n_trmt++;
        if (|ack) n_ack++;
      end
      chk("level_done_one_trmt", n_trmt, 1);
      chk("level_done_no_ack", n_ack, 0);
    end
    force_val = 1'b0;
    repeat (2) @(negedge clk);
    force_val = 1'b1;
    wait_ack(idx, ok);
    chk("level_done_ack_idx", idx, 0);
    req = 2'b00;
    @(negedge clk);
    force_en = 1'b0;
    check_bytes("level_done", 2, 8'hA5, 8'h5A);

    // async reset mid-packet, then req1 served first
    do_reset();
    pkt_data = {16'hC0DE, 16'hA55A};
    pkt_two  = 2'b11;
    req      = 2'b11;
    wait_trmt();
    chk("midrst_first_byte", tx_data, 8'hA5);
    @(negedge clk);
    rst_n = 1'b0;
    req   = 2'b10;
    #1;
    chk("midrst_trmt", trmt, 0);
    chk("midrst_ack", ack, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_tx_data", tx_data, 8'h00);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    byte_log.delete();
    wait_ack(idx, ok);
    chk("midrst_ack_idx", idx, 1);
    req = 2'b00;
    @(negedge clk);
    check_bytes("midrst", 2, 8'hC0, 8'hDE);

    // packet changes after capture
    do_reset();
    pkt_data = {16'h0000, 16'hBEEF};
    pkt_two  = 2'b01;
    req      = 2'b01;
    wait_trmt();
    pkt_data = 32'h0;
    wait_ack(idx, ok);
    chk("capture_ack_idx", idx, 0);
    req = 2'b00;
    @(negedge clk);
    check_bytes("capture", 2, 8'hBE, 8'hEF);

    chk("trmt_ack_overlap", overlap_cnt, 0);
    chk("multi_ack", multi_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
